// File: rtl/src_ctrl_pkg.sv
// Shared encodings for the control sequencer: FSM states, opcodes, ALU codes
// and the control word handed from the decoder to the sequencer outputs.
package src_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_T0,
    S_T1,
    S_T2,
    S_T3,
    S_T4,
    S_T5,
    S_T6,
    S_T7,
    S_HALTED
  } state_t;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b00111;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;

  typedef struct packed {
    logic       gra;
    logic       grb;
    logic       grc;
    logic       rin;
    logic       rout;
    logic       baOut;
    logic       pcOut;
    logic       pcIn;
    logic       incPc;
    logic       marIn;
    logic       mdrIn;
    logic       mdrOut;
    logic       irIn;
    logic       yIn;
    logic       zIn;
    logic       zLowOut;
    logic       cOut;
    logic       read;
    logic       write;
    logic [3:0] aluOp;
    logic       run;
  } ctrl_word_t;

  function automatic logic isAluOp(input logic [4:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
  endfunction

  function automatic logic isImmOp(input logic [4:0] op);
    return (op == OP_ADDI) || (op == OP_LDI);
  endfunction

  function automatic logic isMemOp(input logic [4:0] op);
    return (op == OP_LD) || (op == OP_ST);
  endfunction

  function automatic logic [3:0] aluFor(input logic [4:0] op);
    case (op)
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_word_decode.sv
// Pure combinational decode of (state, latched opcode) into the control word.
module ctrl_word_decode
  import src_ctrl_pkg::*;
(
  input  state_t     state_i,
  input  logic [4:0] opcode_i,
  input  logic       t1Held_i,
  output ctrl_word_t ctrl_o
);

  always_comb begin
    ctrl_o       = '0;
    ctrl_o.aluOp = ALU_ADD;
    ctrl_o.run   = 1'b1;
    case (state_i)
      S_T0: begin
        ctrl_o.pcOut = 1'b1;
        ctrl_o.marIn = 1'b1;
        ctrl_o.incPc = 1'b1;
        ctrl_o.zIn   = 1'b1;
      end
      S_T1: begin
        // PC reload happens once even when the memory wait stretches T1
        ctrl_o.zLowOut = 1'b1;
        ctrl_o.pcIn    = !t1Held_i;
        ctrl_o.read    = 1'b1;
        ctrl_o.mdrIn   = 1'b1;
      end
      S_T2: begin
        ctrl_o.mdrOut = 1'b1;
        ctrl_o.irIn   = 1'b1;
      end
      S_T3: begin
        if (isAluOp(opcode_i) || (opcode_i == OP_ADDI)) begin
          ctrl_o.grb  = 1'b1;
          ctrl_o.rout = 1'b1;
          ctrl_o.yIn  = 1'b1;
        end else if ((opcode_i == OP_LDI) || isMemOp(opcode_i)) begin
          ctrl_o.grb   = 1'b1;
          ctrl_o.baOut = 1'b1;
          ctrl_o.yIn   = 1'b1;
        end
      end
      S_T4: begin
        if (isAluOp(opcode_i)) begin
          ctrl_o.grc   = 1'b1;
          ctrl_o.rout  = 1'b1;
          ctrl_o.zIn   = 1'b1;
          ctrl_o.aluOp = aluFor(opcode_i);
        end else if (isImmOp(opcode_i) || isMemOp(opcode_i)) begin
          ctrl_o.cOut = 1'b1;
          ctrl_o.zIn  = 1'b1;
        end
      end
      S_T5: begin
        if (isAluOp(opcode_i) || isImmOp(opcode_i)) begin
          ctrl_o.zLowOut = 1'b1;
          ctrl_o.gra     = 1'b1;
          ctrl_o.rin     = 1'b1;
        end else if (isMemOp(opcode_i)) begin
          ctrl_o.zLowOut = 1'b1;
          ctrl_o.marIn   = 1'b1;
        end
      end
      S_T6: begin
        if (opcode_i == OP_LD) begin
          ctrl_o.read  = 1'b1;
          ctrl_o.mdrIn = 1'b1;
        end else if (opcode_i == OP_ST) begin
          ctrl_o.gra   = 1'b1;
          ctrl_o.rout  = 1'b1;
          ctrl_o.mdrIn = 1'b1;
        end
      end
      S_T7: begin
        if (opcode_i == OP_LD) begin
          ctrl_o.mdrOut = 1'b1;
          ctrl_o.gra    = 1'b1;
          ctrl_o.rin    = 1'b1;
        end else if (opcode_i == OP_ST) begin
          ctrl_o.write = 1'b1;
        end
      end
      S_HALTED: ctrl_o.run = 1'b0;
      default: ;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Moore control sequencer: state register, opcode latch and next-state logic;
// the control word itself comes from ctrl_word_decode.
module control_sequencer
  import src_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] IR,
  input  logic        mem_ack,
  input  logic        stop,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        PCout,
  output logic        PCin,
  output logic        IncPC,
  output logic        MARin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        Zlowout,
  output logic        Cout,
  output logic        Read,
  output logic        Write,
  output logic [3:0]  alu_op,
  output logic        run
);

  state_t     state_q, state_d, finishState;
  logic [4:0] opcode_q, opcode_d;
  logic       t1Held_q, t1Held_d;
  logic [26:0] irUnused;
  ctrl_word_t ctrl;

  assign irUnused = IR[26:0];

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q  <= S_IDLE;
      opcode_q <= OP_LD;
      t1Held_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      t1Held_q <= t1Held_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    opcode_d    = opcode_q;
    finishState = stop ? S_HALTED : S_T0;
    case (state_q)
      S_IDLE: state_d = S_T0;
      S_T0:   state_d = S_T1;
      S_T1:   if (mem_ack) state_d = S_T2;
      S_T2: begin
        state_d  = S_T3;
        opcode_d = IR[31:27];
      end
      S_T3: begin
        if (opcode_q == OP_HALT) state_d = S_HALTED;
        else if (isAluOp(opcode_q) || isImmOp(opcode_q) || isMemOp(opcode_q)) state_d = S_T4;
        else state_d = finishState;
      end
      S_T4:   state_d = S_T5;
      S_T5:   state_d = isMemOp(opcode_q) ? S_T6 : finishState;
      S_T6:   if ((opcode_q == OP_ST) || mem_ack) state_d = S_T7;
      // A store finishes only once its write is acknowledged
      S_T7:   if ((opcode_q != OP_ST) || mem_ack) state_d = finishState;
      S_HALTED: state_d = S_HALTED;
      default: state_d = S_IDLE;
    endcase
    t1Held_d = (state_q == S_T1) && (state_d == S_T1);
  end

  ctrl_word_decode u_decode (
    .state_i  (state_q),
    .opcode_i (opcode_q),
    .t1Held_i (t1Held_q),
    .ctrl_o   (ctrl)
  );

  assign Gra     = ctrl.gra;
  assign Grb     = ctrl.grb;
  assign Grc     = ctrl.grc;
  assign Rin     = ctrl.rin;
  assign Rout    = ctrl.rout;
  assign BAout   = ctrl.baOut;
  assign PCout   = ctrl.pcOut;
  assign PCin    = ctrl.pcIn;
  assign IncPC   = ctrl.incPc;
  assign MARin   = ctrl.marIn;
  assign MDRin   = ctrl.mdrIn;
  assign MDRout  = ctrl.mdrOut;
  assign IRin    = ctrl.irIn;
  assign Yin     = ctrl.yIn;
  assign Zin     = ctrl.zIn;
  assign Zlowout = ctrl.zLowOut;
  assign Cout    = ctrl.cOut;
  assign Read    = ctrl.read;
  assign Write   = ctrl.write;
  assign alu_op  = ctrl.aluOp;
  assign run     = ctrl.run;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: every cycle of each instruction is
// compared against a hand-written control word.
module tb_control_sequencer;
  import src_ctrl_pkg::*;

  logic        clock, reset, mem_ack, stop;
  logic [31:0] IR;
  logic Gra, Grb, Grc, Rin, Rout, BAout, PCout, PCin, IncPC, MARin, MDRin;
  logic MDRout, IRin, Yin, Zin, Zlowout, Cout, Read, Write, run;
  logic [3:0]  alu_op;
  logic [23:0] obs;

  int assertCount = 0;
  int failCount   = 0;

  localparam logic [18:0] GRA     = 19'd1 << 18;
  localparam logic [18:0] GRB     = 19'd1 << 17;
  localparam logic [18:0] GRC     = 19'd1 << 16;
  localparam logic [18:0] RIN     = 19'd1 << 15;
  localparam logic [18:0] ROUT    = 19'd1 << 14;
  localparam logic [18:0] BAOUT   = 19'd1 << 13;
  localparam logic [18:0] PCOUT   = 19'd1 << 12;
  localparam logic [18:0] PCIN    = 19'd1 << 11;
  localparam logic [18:0] INCPC   = 19'd1 << 10;
  localparam logic [18:0] MARIN   = 19'd1 << 9;
  localparam logic [18:0] MDRIN   = 19'd1 << 8;
  localparam logic [18:0] MDROUT  = 19'd1 << 7;
  localparam logic [18:0] IRIN    = 19'd1 << 6;
  localparam logic [18:0] YIN     = 19'd1 << 5;
  localparam logic [18:0] ZIN     = 19'd1 << 4;
  localparam logic [18:0] ZLOWOUT = 19'd1 << 3;
  localparam logic [18:0] COUT    = 19'd1 << 2;
  localparam logic [18:0] READ    = 19'd1 << 1;
  localparam logic [18:0] WRITE   = 19'd1 << 0;

  localparam logic [23:0] eIdle   = {19'd0, ALU_ADD, 1'b1};
  localparam logic [23:0] eHalted = {19'd0, ALU_ADD, 1'b0};
  localparam logic [23:0] eT0     = {PCOUT | MARIN | INCPC | ZIN, ALU_ADD, 1'b1};
  localparam logic [23:0] eT1f    = {ZLOWOUT | PCIN | READ | MDRIN, ALU_ADD, 1'b1};
  localparam logic [23:0] eT1h    = {ZLOWOUT | READ | MDRIN, ALU_ADD, 1'b1};
  localparam logic [23:0] eT2     = {MDROUT | IRIN, ALU_ADD, 1'b1};

  assign obs = {Gra, Grb, Grc, Rin, Rout, BAout, PCout, PCin, IncPC, MARin, MDRin,
                MDRout, IRin, Yin, Zin, Zlowout, Cout, Read, Write, alu_op, run};

  control_sequencer dut (
    .clk(clock), .clr(reset), .IR(IR), .mem_ack(mem_ack), .stop(stop),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin),
    .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zin(Zin), .Zlowout(Zlowout),
    .Cout(Cout), .Read(Read), .Write(Write), .alu_op(alu_op), .run(run)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [23:0] word(input logic [18:0] s, input logic [3:0] a, input logic r);
    return {s, a, r};
  endfunction

  task automatic checkOutput(input string tag, input logic [23:0] observed, input logic [23:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic ack, input logic stp);
    mem_ack = ack;
    stop    = stp;
  endtask

  task automatic tick;
    @(posedge clock);
    @(negedge clock);
  endtask

  // Entered at the negedge of T0; leaves at the negedge of T3
  task automatic fetch(input string name, input logic [31:0] instr, input int ackCycles);
    IR = instr;
    checkOutput({name, ".T0"}, obs, eT0);
    applyStimulus(1'b0, 1'b0);
    tick;
    for (int k = 1; k <= ackCycles; k++) begin
      checkOutput({name, ".T1"}, obs, (k == 1) ? eT1f : eT1h);
      applyStimulus(k == ackCycles, 1'b0);
      tick;
    end
    applyStimulus(1'b0, 1'b0);
    checkOutput({name, ".T2"}, obs, eT2);
    tick;
  endtask

  task automatic aluInstr(input string name, input logic [31:0] instr, input logic [3:0] alu);
    fetch(name, instr, 1);
    checkOutput({name, ".T3"}, obs, word(GRB | ROUT | YIN, ALU_ADD, 1'b1));
    tick;
    checkOutput({name, ".T4"}, obs, word(GRC | ROUT | ZIN, alu, 1'b1));
    tick;
    checkOutput({name, ".T5"}, obs, word(ZLOWOUT | GRA | RIN, ALU_ADD, 1'b1));
    tick;
  endtask

  task automatic immInstr(input string name, input logic [31:0] instr, input logic [18:0] t3);
    fetch(name, instr, 2);
    checkOutput({name, ".T3"}, obs, word(t3, ALU_ADD, 1'b1));
    tick;
    checkOutput({name, ".T4"}, obs, word(COUT | ZIN, ALU_ADD, 1'b1));
    tick;
    checkOutput({name, ".T5"}, obs, word(ZLOWOUT | GRA | RIN, ALU_ADD, 1'b1));
    tick;
  endtask

  // Halted state must ignore mem_ack/stop; clr then brings it back to IDLE
  task automatic haltHoldAndClear(input string name);
    checkOutput({name, ".halted"}, obs, eHalted);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(k[0], !k[0]);
      tick;
      checkOutput({name, ".haltHold"}, obs, eHalted);
    end
    applyStimulus(1'b0, 1'b0);
    reset = 1'b1;
    #1 checkOutput({name, ".clr"}, obs, eIdle);
    #2 reset = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    reset = 1'b1;
    IR    = 32'h0;
    applyStimulus(1'b0, 1'b0);
    #1 checkOutput("reset.async", obs, eIdle);
    @(negedge clock);
    checkOutput("reset.held", obs, eIdle);
    reset = 1'b0;
    tick;

    aluInstr("add", 32'h18918000, ALU_ADD);
    aluInstr("sub", 32'h20000000, ALU_SUB);
    aluInstr("and", 32'h28000000, ALU_AND);
    aluInstr("or",  32'h30000000, ALU_OR);
    immInstr("addi", 32'h38000000, GRB | ROUT | YIN);
    immInstr("ldi",  32'h08000000, GRB | BAOUT | YIN);

    fetch("ld", 32'h00000000, 3);
    checkOutput("ld.T3", obs, word(GRB | BAOUT | YIN, ALU_ADD, 1'b1));
    applyStimulus(1'b1, 1'b0);
    tick;
    checkOutput("ld.T4", obs, word(COUT | ZIN, ALU_ADD, 1'b1));
    applyStimulus(1'b0, 1'b0);
    tick;
    checkOutput("ld.T5", obs, word(ZLOWOUT | MARIN, ALU_ADD, 1'b1));
    tick;
    for (int k = 1; k <= 3; k++) begin
      checkOutput("ld.T6", obs, word(READ | MDRIN, ALU_ADD, 1'b1));
      applyStimulus(k == 3, 1'b0);
      tick;
    end
    applyStimulus(1'b0, 1'b0);
    checkOutput("ld.T7", obs, word(MDROUT | GRA | RIN, ALU_ADD, 1'b1));
    tick;

    fetch("st", 32'h10000000, 1);
    checkOutput("st.T3", obs, word(GRB | BAOUT | YIN, ALU_ADD, 1'b1));
    tick;
    checkOutput("st.T4", obs, word(COUT | ZIN, ALU_ADD, 1'b1));
    tick;
    checkOutput("st.T5", obs, word(ZLOWOUT | MARIN, ALU_ADD, 1'b1));
    tick;
    checkOutput("st.T6", obs, word(GRA | ROUT | MDRIN, ALU_ADD, 1'b1));
    applyStimulus(1'b1, 1'b0);
    tick;
    applyStimulus(1'b0, 1'b0);
    checkOutput("st.T7a", obs, word(WRITE, ALU_ADD, 1'b1));
    tick;
    checkOutput("st.T7b", obs, word(WRITE, ALU_ADD, 1'b1));
    applyStimulus(1'b1, 1'b0);
    tick;
    applyStimulus(1'b0, 1'b0);

    fetch("nop", 32'h40000000, 1);
    checkOutput("nop.T3", obs, eIdle);
    tick;

    fetch("addStop", 32'h18918000, 1);
    checkOutput("addStop.T3", obs, word(GRB | ROUT | YIN, ALU_ADD, 1'b1));
    tick;
    checkOutput("addStop.T4", obs, word(GRC | ROUT | ZIN, ALU_ADD, 1'b1));
    applyStimulus(1'b0, 1'b1);
    tick;
    checkOutput("addStop.T5", obs, word(ZLOWOUT | GRA | RIN, ALU_ADD, 1'b1));
    tick;
    haltHoldAndClear("addStop");

    fetch("halt", 32'hD8000000, 1);
    checkOutput("halt.T3", obs, eIdle);
    tick;
    haltHoldAndClear("halt");

    fetch("ldClr", 32'h00000000, 1);
    tick;
    tick;
    tick;
    checkOutput("ldClr.T6", obs, word(READ | MDRIN, ALU_ADD, 1'b1));
    reset = 1'b1;
    #1 checkOutput("ldClr.async", obs, eIdle);
    #2 reset = 1'b0;
    @(negedge clock);
    aluInstr("addAfterClr", 32'h18918000, ALU_ADD);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
